bingo_card_ctrl: RTL
====================

# bingo_card_ctrl

Game engine directly downstream of the keypad controller. Captures the player's card from the two-digit BCD entries the keypad produces, then, on the start key, draws pseudo-random unique numbers at a fixed cadence. Each draw is matched against the card, and `bingo` is raised when every card number has been drawn. Outputs feed the display and LED stage.

## Interface
Parameters:
- `CARD_SIZE`, 4: numbers on the card (1–8).
- `MAX_NUM`, 75: highest legal bingo number (≤ 99).
- `DRAW_CYCLES`, 50_000_000: clock cycles between draw requests.

Ports:
- `clk`: in, 1, system clock.
- `rst`: in, 1, synchronous, active-high reset.
- `start_game`: in, 1, start key level from the keypad controller.
- `num_count`: in, 2, digits entered in the current entry (0–2).
- `cascade_reg`: in, 8, `[7:4]` tens digit, `[3:0]` units digit, BCD.
- `state_o`: out, 2, current FSM state encoding.
- `entry_err`: out, 1, one-cycle pulse when an entry is rejected.
- `card_cnt`: out, 4, numbers stored so far.
- `drawn_valid`: out, 1, one-cycle pulse when a new number is drawn.
- `drawn_bcd`: out, 8, last drawn number, BCD.
- `draw_cnt`: out, 7, numbers drawn this game.
- `hit_mask`: out, `CARD_SIZE`, bit i set once card slot i has been drawn.
- `bingo`: out, 1, level, high in the WIN state.

## Operation
- FSM states: ENTRY=0, READY=1, PLAY=2, WIN=3.
- Reset: state ENTRY. Card, drawn bitmap, `hit_mask`, `card_cnt`, `draw_cnt`, `drawn_bcd` and the draw timer all cleared. `entry_err`, `drawn_valid` and `bingo` are 0. LFSR = 7'h01.
- LFSR: 7-bit Fibonacci, x^7+x^6+1. `next = {lfsr[5:0], lfsr[6]^lfsr[5]}`. Advances every cycle in every state; never holds 0.
- Commit event: rising edge of `num_count==2`, detected with one registered copy.
  - Only acted on in ENTRY.
  - Value = `tens*10 + units`.
  - Rejected, with an `entry_err` pulse, if either digit > 9, value is 0, value > `MAX_NUM`, or value is already on the card.
  - Otherwise the value is stored in slot `card_cnt` and `card_cnt` increments.
- ENTRY→READY when `card_cnt` reaches `CARD_SIZE`. Further commits are ignored with no error pulse.
- READY→PLAY on a rising edge of `start_game`, with the draw timer cleared. `start_game` in ENTRY is ignored.
- PLAY:
  - The timer counts to `DRAW_CYCLES-1`, then sets `draw_pending` and wraps.
  - While pending, each cycle the LFSR value is tested. It is accepted if it is ≤ `MAX_NUM` and its bitmap bit is clear; otherwise it is retried on the next cycle.
  - On acceptance, the following all take effect at the same edge:
    - set the bitmap bit;
    - `drawn_bcd` = BCD of the value;
    - `draw_cnt++`;
    - `drawn_valid` pulses;
    - card slots equal to the value set their `hit_mask` bit;
    - `draw_pending` clears.
  - A timer expiry while a draw is still pending is absorbed, so at most one draw is pending.
- PLAY→WIN the cycle after `hit_mask` becomes all ones. `bingo`=1 in WIN.
- WIN→ENTRY on a rising edge of `start_game`. Card, bitmap, mask and counters are cleared; the LFSR is not cleared.
- `rst` mid-operation has immediate effect from any state.

## Timing
- Commit → `card_cnt`/`entry_err`: the `num_count==2` edge is seen at edge N; the update is registered at edge N+1.
- Last valid commit → `state_o`=READY one edge later.
- Start edge → PLAY in 1 cycle. The first draw request comes `DRAW_CYCLES` cycles after entering PLAY.
- Draw latency after the request: 1 + number of rejected LFSR samples.
- `hit_mask` updates with `drawn_valid`. `bingo` rises exactly one cycle after the final hit.
- All outputs are registered.

## Structure
- Package `bingo_pkg`:
  - state enum;
  - `LFSR_SEED`;
  - `bcd2bin`/`bin2bcd` functions, with the digit-range check.
- Sub-module `lfsr7`: free-running generator with synchronous reset.
- The draw timer may reuse the existing parameterised `counter`.
- Bitmap is `MAX_NUM` flops. Card is `CARD_SIZE`×7-bit registers.

## Test plan
- Reset, then enter 12, 34, 05, 70 (`CARD_SIZE`=4, `DRAW_CYCLES`=8) → `card_cnt` 1..4; `state_o` goes 0→1; no `entry_err`.
- During entry, submit 12 again, then 00, 80, then tens digit B → four `entry_err` pulses; `card_cnt` unchanged.
- `start_game` pulse while in ENTRY with 2 numbers stored → stays in ENTRY. In READY, the pulse → PLAY next cycle.
- PLAY with a bench-side LFSR model:
  - each `drawn_valid` matches the model's first accepted value (≤ 75, unique);
  - `drawn_bcd` is correct BCD;
  - `draw_cnt` increments;
  - no repeats over 75 draws.
- Card containing numbers drawn → matching `hit_mask` bits set on the `drawn_valid` cycle; `bingo`=1 one cycle after the mask is 4'hF. A further `start_game` → ENTRY with all state cleared.
- Assert `rst` mid-PLAY with a draw pending → next cycle in ENTRY, all outputs at reset values, no `drawn_valid`.

Source files
------------

// File: rtl/bingo_pkg.sv
// Shared types and helpers for the bingo game engine.
package bingo_pkg;

  typedef enum logic [1:0] {
    StEntry = 2'd0,
    StReady = 2'd1,
    StPlay  = 2'd2,
    StWin   = 2'd3
  } state_e;

  localparam logic [6:0] LFSR_SEED = 7'h01;

  function automatic logic bcd_ok(input logic [7:0] bcd);
    return (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
  endfunction

  // Only meaningful when bcd_ok() holds; out-of-range digits may wrap.
  function automatic logic [6:0] bcd2bin(input logic [7:0] bcd);
    return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
    return {4'(bin / 7'd10), 4'(bin % 7'd10)};
  endfunction

endpackage

// File: rtl/lfsr7.sv
// Free-running 7-bit Fibonacci LFSR, x^7+x^6+1, never reaches zero.
module lfsr7
  import bingo_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [6:0] lfsr_o
);

  logic [6:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/bingo_card_ctrl.sv
// Bingo engine: captures the card from keypad BCD entries, then draws unique
// pseudo-random numbers at a fixed cadence and flags bingo when the card is covered.
module bingo_card_ctrl
  import bingo_pkg::*;
#(
  parameter int unsigned CARD_SIZE   = 4,
  parameter int unsigned MAX_NUM     = 75,
  parameter int unsigned DRAW_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_game,
  input  logic [1:0]           num_count,
  input  logic [7:0]           cascade_reg,
  output logic [1:0]           state_o,
  output logic                 entry_err,
  output logic [3:0]           card_cnt,
  output logic                 drawn_valid,
  output logic [7:0]           drawn_bcd,
  output logic [6:0]           draw_cnt,
  output logic [CARD_SIZE-1:0] hit_mask,
  output logic                 bingo
);

  localparam int unsigned       TimerW    = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(DRAW_CYCLES - 1);

  state_e               state_q;
  logic [6:0]           lfsr;
  logic                 nc2_q, commit_q, start_q, pending_q;
  logic [7:0]           entry_q;
  logic [6:0]           card_q [CARD_SIZE];
  logic [MAX_NUM-1:0]   drawn_q;
  logic [TimerW-1:0]    timer_q;
  logic [3:0]           card_cnt_q;
  logic [6:0]           draw_cnt_q;
  logic [7:0]           drawn_bcd_q;
  logic [CARD_SIZE-1:0] hit_q;
  logic                 err_q, valid_q, bingo_q;

  logic [6:0]           entry_val, lfsr_idx;
  logic [MAX_NUM-1:0]   drawn_sh;
  logic                 entry_dup, entry_bad, start_rise, draw_ok, timer_wrap;
  logic [CARD_SIZE-1:0] hit_now;

  lfsr7 u_lfsr (
    .clk_i  (clk),
    .rst_i  (rst),
    .lfsr_o (lfsr)
  );

  always_comb begin
    entry_val = bcd2bin(entry_q);
    entry_dup = 1'b0;
    hit_now   = '0;
    for (int i = 0; i < int'(CARD_SIZE); i++) begin
      if (i < int'(card_cnt_q) && card_q[i] == entry_val) entry_dup = 1'b1;
      if (card_q[i] == lfsr) hit_now[i] = 1'b1;
    end
    entry_bad  = !bcd_ok(entry_q) || (entry_val == 7'd0) ||
                 (int'(entry_val) > int'(MAX_NUM)) || entry_dup;
    lfsr_idx   = lfsr - 7'd1;
    drawn_sh   = drawn_q >> lfsr_idx;
    // Out-of-range samples are retried, as are numbers already drawn.
    draw_ok    = pending_q && (int'(lfsr) <= int'(MAX_NUM)) && !drawn_sh[0];
    start_rise = start_game && !start_q;
    timer_wrap = (timer_q == TimerLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEntry;
      nc2_q       <= 1'b0;
      commit_q    <= 1'b0;
      start_q     <= 1'b0;
      pending_q   <= 1'b0;
      entry_q     <= '0;
      drawn_q     <= '0;
      timer_q     <= '0;
      card_cnt_q  <= '0;
      draw_cnt_q  <= '0;
      drawn_bcd_q <= '0;
      hit_q       <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      bingo_q     <= 1'b0;
      for (int i = 0; i < int'(CARD_SIZE); i++) card_q[i] <= '0;
    end else begin
      nc2_q    <= (num_count == 2'd2);
      commit_q <= (num_count == 2'd2) && !nc2_q;
      entry_q  <= cascade_reg;
      start_q  <= start_game;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      unique case (state_q)
        StEntry: begin
          if (card_cnt_q == 4'(CARD_SIZE)) begin
            state_q <= StReady;
          end else if (commit_q) begin
            if (entry_bad) begin
              err_q <= 1'b1;
            end else begin
              for (int i = 0; i < int'(CARD_SIZE); i++) begin
                if (i == int'(card_cnt_q)) card_q[i] <= entry_val;
              end
              card_cnt_q <= card_cnt_q + 4'd1;
            end
          end
        end
        StReady: begin
          if (start_rise) begin
            state_q   <= StPlay;
            timer_q   <= '0;
            pending_q <= 1'b0;
          end
        end
        StPlay: begin
          if (&hit_q) begin
            state_q <= StWin;
            bingo_q <= 1'b1;
          end else begin
            timer_q <= timer_wrap ? '0 : timer_q + 1'b1;
            // An expiry while a draw is outstanding is absorbed.
            if (pending_q) begin
              if (draw_ok) begin
                drawn_q     <= drawn_q | (MAX_NUM'(1) << lfsr_idx);
                drawn_bcd_q <= bin2bcd(lfsr);
                draw_cnt_q  <= draw_cnt_q + 7'd1;
                valid_q     <= 1'b1;
                hit_q       <= hit_q | hit_now;
                pending_q   <= 1'b0;
              end
            end else if (timer_wrap) begin
              pending_q <= 1'b1;
            end
          end
        end
        StWin: begin
          if (start_rise) begin
            state_q     <= StEntry;
            bingo_q     <= 1'b0;
            drawn_q     <= '0;
            timer_q     <= '0;
            pending_q   <= 1'b0;
            card_cnt_q  <= '0;
            draw_cnt_q  <= '0;
            drawn_bcd_q <= '0;
            hit_q       <= '0;
            for (int i = 0; i < int'(CARD_SIZE); i++) card_q[i] <= '0;
          end
        end
      endcase
    end
  end

  assign state_o     = state_q;
  assign entry_err   = err_q;
  assign card_cnt    = card_cnt_q;
  assign drawn_valid = valid_q;
  assign drawn_bcd   = drawn_bcd_q;
  assign draw_cnt    = draw_cnt_q;
  assign hit_mask    = hit_q;
  assign bingo       = bingo_q;

endmodule
